// File: rtl/audio_pwm_out.sv
// PWM audio output stage with a soft-start/soft-stop duty ramp to avoid pops.
// Optional macro AUDIO_PWM_DITHER_EN adds LFSR dither of the duty while in RUN.
module audio_pwm_out #(
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] sample_data_i,
  output logic       pwm_o,
  output logic       period_start_o,
  output logic [1:0] state_o,
  output logic       active_o
);

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [8:0]      STEP      = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // One ramp step toward tgt; 9-bit compares so nothing can wrap.
  function automatic logic [7:0] ramp_to(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c;
    logic [8:0] t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) ramp_to = ((t - c) <= STEP) ? tgt : 8'(c + STEP);
    else        ramp_to = ((c - t) <= STEP) ? tgt : 8'(c - STEP);
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] cur);
    logic [8:0] c;
    c = {1'b0, cur};
    step_down = (c <= STEP) ? 8'd0 : 8'(c - STEP);
  endfunction

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_q, duty_d;
  state_t        state_q, state_d;
  logic          pwm_q, pwm_d;
  logic          period_start_q, period_start_d;
  logic          active_q, active_d;
  logic          tick, boundary;
  logic [7:0]    run_duty;

`ifdef AUDIO_PWM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  dith_sum;
  always_comb begin
    dith_sum = {1'b0, sample_data_i} + {8'd0, lfsr_q[0]};
    run_duty = dith_sum[8] ? 8'hFF : dith_sum[7:0];
    lfsr_d   = lfsr_q;
    if (boundary && state_d == RUN)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`else
  always_comb run_duty = sample_data_i;
`endif

  always_comb begin
    tick           = (presc_cnt_q == PRESC_MAX);
    boundary       = tick && (pwm_cnt_q == 8'hFF);
    presc_cnt_d    = tick ? '0 : PW'(presc_cnt_q + 1'b1);
    pwm_cnt_d      = tick ? 8'(pwm_cnt_q + 8'd1) : pwm_cnt_q;
    period_start_d = boundary;
    pwm_d          = (pwm_cnt_q < duty_q);
    state_d        = state_q;
    duty_d         = duty_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          duty_d = 8'd0;
          if (enable_i) begin
            state_d = RAMP_UP;
            duty_d  = ramp_to(8'd0, sample_data_i);
          end
        end
        RAMP_UP: begin
          if (!enable_i) begin
            state_d = RAMP_DOWN;
            duty_d  = step_down(duty_q);
          end else begin
            duty_d = ramp_to(duty_q, sample_data_i);
            if (duty_d == sample_data_i) state_d = RUN;
          end
        end
        RUN: begin
          if (enable_i) duty_d = run_duty;
          else begin
            state_d = RAMP_DOWN;
            duty_d  = step_down(duty_q);
          end
        end
        RAMP_DOWN: begin
          if (enable_i) begin
            state_d = RAMP_UP;
            duty_d  = ramp_to(duty_q, sample_data_i);
          end else begin
            duty_d = step_down(duty_q);
            if (duty_d == 8'd0) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt_q    <= '0;
      pwm_cnt_q      <= 8'd0;
      duty_q         <= 8'd0;
      state_q        <= IDLE;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      active_q       <= 1'b0;
`ifdef AUDIO_PWM_DITHER_EN
      lfsr_q         <= 16'hACE1;
`endif
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_q         <= duty_d;
      state_q        <= state_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      active_q       <= active_d;
`ifdef AUDIO_PWM_DITHER_EN
      lfsr_q         <= lfsr_d;
`endif
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;
  assign state_o        = state_q;
  assign active_o       = active_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: ramp FSM, sample capture, reset, prescaler.
module tb_audio_pwm_out;
  logic       clk = 1'b0;
  logic       rst, en1, en4;
  logic [7:0] s1, s4;
  logic       pwm1, ps1, act1, pwm4, ps4, act4;
  logic [1:0] st1, st4;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_pwm_out #(.PRESCALE(1), .RAMP_STEP(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .sample_data_i(s1),
    .pwm_o(pwm1), .period_start_o(ps1), .state_o(st1), .active_o(act1));

  audio_pwm_out #(.PRESCALE(4), .RAMP_STEP(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en4), .sample_data_i(s4),
    .pwm_o(pwm4), .period_start_o(ps4), .state_o(st4), .active_o(act4));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // Counts pwm high cycles over the 256 cycles after a period_start negedge.
  task automatic measure1(input int chg_at, input logic [7:0] chg_val, output int cnt, output int first);
    cnt = 0; first = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i == chg_at) s1 = chg_val;
      if (pwm1) begin cnt++; if (first == 0) first = i; end
    end
  endtask

  task automatic measure4(output int cnt, output int pulses, output int last_ps);
    cnt = 0; pulses = 0; last_ps = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (pwm4) cnt++;
      if (ps4) begin pulses++; last_ps = i; end
    end
  endtask

  task automatic wait_ps(input bit which4, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ((which4 ? ps4 : ps1) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int pulses, last, hi, stnz, actc;
    rst = 1; en1 = 0; s1 = 0; en4 = 0; s4 = 0;
    repeat (2) @(negedge clk);
    tests++; if (pwm1 !== 1'b0) begin fails++; $display("FAIL reset_pwm got %b want 0", pwm1); end
    tests++; if (ps1 !== 1'b0) begin fails++; $display("FAIL reset_ps got %b want 0", ps1); end
    tests++; if (st1 !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", st1); end
    tests++; if (act1 !== 1'b0) begin fails++; $display("FAIL reset_active got %b want 0", act1); end
    tests++; if (st4 !== 2'd0) begin fails++; $display("FAIL reset_state4 got %0d want 0", st4); end
    rst = 0;
    pulses = 0; last = 0; hi = 0; stnz = 0; actc = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (ps1) begin pulses++; last = i; end
      if (pwm1 !== 1'b0) hi++;
      if (st1 !== 2'd0) stnz++;
      if (act1 !== 1'b0) actc++;
    end
    tests++; if (pulses != 4) begin fails++; $display("FAIL idle_pulses got %0d want 4", pulses); end
    tests++; if (last != 1024) begin fails++; $display("FAIL idle_last_pulse got %0d want 1024", last); end
    tests++; if (hi != 0) begin fails++; $display("FAIL idle_pwm_high got %0d want 0", hi); end
    tests++; if (stnz != 0) begin fails++; $display("FAIL idle_state_nonzero got %0d want 0", stnz); end
    tests++; if (actc != 0) begin fails++; $display("FAIL idle_active got %0d want 0", actc); end
  endtask

  task automatic test_ramp_up();
    int c, f;
    en1 = 1; s1 = 8'd128;
    measure1(0, 8'd0, c, f);
    tests++; if (c != 0) begin fails++; $display("FAIL rampup_first_period got %0d want 0", c); end
    tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL rampup_state got %0d want 1", st1); end
    tests++; if (act1 !== 1'b1) begin fails++; $display("FAIL rampup_active got %b want 1", act1); end
    for (int k = 1; k <= 8; k++) begin
      measure1(0, 8'd0, c, f);
      tests++; if (c != 16 * k) begin fails++; $display("FAIL rampup_duty_%0d got %0d want %0d", k, c, 16 * k); end
      tests++;
      if (st1 !== ((k >= 7) ? 2'd2 : 2'd1)) begin
        fails++; $display("FAIL rampup_state_%0d got %0d want %0d", k, st1, (k >= 7) ? 2 : 1);
      end
      if (k == 8) begin
        tests++; if (f != 1) begin fails++; $display("FAIL run_first_high got %0d want 1", f); end
        tests++; if (ps1 !== 1'b1) begin fails++; $display("FAIL run_period_start got %b want 1", ps1); end
      end
    end
  endtask

  task automatic test_run_samples();
    int c, f;
    measure1(100, 8'd0, c, f);
    tests++; if (c != 128) begin fails++; $display("FAIL run_hold128 got %0d want 128", c); end
    measure1(100, 8'd255, c, f);
    tests++; if (c != 0) begin fails++; $display("FAIL run_s0 got %0d want 0", c); end
    measure1(100, 8'd64, c, f);
    tests++; if (c != 255) begin fails++; $display("FAIL run_s255 got %0d want 255", c); end
    measure1(100, 8'd200, c, f);
    tests++; if (c != 64) begin fails++; $display("FAIL run_s64 got %0d want 64", c); end
    measure1(0, 8'd0, c, f);
    tests++; if (c != 200) begin fails++; $display("FAIL run_s200 got %0d want 200", c); end
    tests++; if (st1 !== 2'd2) begin fails++; $display("FAIL run_state got %0d want 2", st1); end
  endtask

  task automatic test_ramp_down();
    int c, f;
    en1 = 0;
    measure1(0, 8'd0, c, f);
    tests++; if (c != 200) begin fails++; $display("FAIL rdown_start got %0d want 200", c); end
    tests++; if (st1 !== 2'd3) begin fails++; $display("FAIL rdown_state got %0d want 3", st1); end
    for (int k = 1; k <= 12; k++) begin
      measure1(0, 8'd0, c, f);
      tests++; if (c != 200 - 16 * k) begin fails++; $display("FAIL rdown_duty_%0d got %0d want %0d", k, c, 200 - 16 * k); end
      tests++;
      if (st1 !== ((k < 12) ? 2'd3 : 2'd0)) begin
        fails++; $display("FAIL rdown_state_%0d got %0d want %0d", k, st1, (k < 12) ? 3 : 0);
      end
    end
    tests++; if (act1 !== 1'b0) begin fails++; $display("FAIL rdown_active got %b want 0", act1); end
    measure1(0, 8'd0, c, f);
    tests++; if (c != 0) begin fails++; $display("FAIL rdown_idle_duty got %0d want 0", c); end
  endtask

  task automatic test_reverse_and_reset();
    int c, f, n, hi;
    bit ok;
    en1 = 1; s1 = 8'd136;
    for (int i = 0; i < 20; i++) begin
      wait_ps(1'b0, ok);
      if (!ok || st1 == 2'd2) break;
    end
    tests++; if (st1 !== 2'd2) begin fails++; $display("FAIL rev_reach_run got %0d want 2", st1); end
    en1 = 0;
    wait_ps(1'b0, ok);
    tests++; if (!ok || st1 !== 2'd3) begin fails++; $display("FAIL rev_rdown got %0d want 3", st1); end
    en1 = 1; s1 = 8'd100;
    measure1(0, 8'd0, c, f);
    tests++; if (c != 120) begin fails++; $display("FAIL rev_duty120 got %0d want 120", c); end
    tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL rev_rampup got %0d want 1", st1); end
    measure1(0, 8'd0, c, f);
    tests++; if (c != 104) begin fails++; $display("FAIL rev_duty104 got %0d want 104", c); end
    tests++; if (st1 !== 2'd2) begin fails++; $display("FAIL rev_run got %0d want 2", st1); end
    measure1(0, 8'd0, c, f);
    tests++; if (c != 100) begin fails++; $display("FAIL rev_duty100 got %0d want 100", c); end
    repeat (50) @(negedge clk);
    tests++; if (pwm1 !== 1'b1) begin fails++; $display("FAIL pre_reset_pwm got %b want 1", pwm1); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests++; if (pwm1 !== 1'b0) begin fails++; $display("FAIL midreset_pwm got %b want 0", pwm1); end
    tests++; if (st1 !== 2'd0) begin fails++; $display("FAIL midreset_state got %0d want 0", st1); end
    tests++; if (act1 !== 1'b0) begin fails++; $display("FAIL midreset_active got %b want 0", act1); end
    tests++; if (ps1 !== 1'b0) begin fails++; $display("FAIL midreset_ps got %b want 0", ps1); end
    n = 0; hi = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (pwm1) hi++;
      if (ps1) begin n = i; break; end
    end
    tests++; if (n != 256) begin fails++; $display("FAIL midreset_counter got %0d want 256", n); end
    tests++; if (hi != 0) begin fails++; $display("FAIL midreset_duty got %0d want 0", hi); end
  endtask

  task automatic test_prescale();
    int c, p, l;
    bit ok;
    en4 = 1; s4 = 8'd32;
    for (int i = 0; i < 10; i++) begin
      wait_ps(1'b1, ok);
      if (!ok || st4 == 2'd2) break;
    end
    tests++; if (st4 !== 2'd2) begin fails++; $display("FAIL p4_reach_run got %0d want 2", st4); end
    measure4(c, p, l);
    tests++; if (c != 128) begin fails++; $display("FAIL p4_duty32 got %0d want 128", c); end
    tests++; if (p != 1 || l != 1024) begin fails++; $display("FAIL p4_period got pulses %0d at %0d want 1 at 1024", p, l); end
    s4 = 8'd255;
    measure4(c, p, l);
    tests++; if (c != 128) begin fails++; $display("FAIL p4_hold32 got %0d want 128", c); end
    measure4(c, p, l);
    tests++; if (c != 1020) begin fails++; $display("FAIL p4_duty255 got %0d want 1020", c); end
    measure4(c, p, l);
    tests++; if (c != 1020) begin fails++; $display("FAIL p4_duty255_again got %0d want 1020", c); end
    tests++; if (st4 !== 2'd2) begin fails++; $display("FAIL p4_state got %0d want 2", st4); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_run_samples();
    test_ramp_down();
    test_reverse_and_reset();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
